// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared state encoding and default widths for the period meter and synth divider.
package period_meter_pkg;
    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 50_000_000;
    typedef enum logic {IDLE, MEASURE} state_t;
endpackage

// File: rtl/period_meter_if.sv
// period_meter_if: pulse input, soft clear and measurement results of the period meter.
interface period_meter_if #(parameter int WIDTH = 32);
    logic             clear;
    logic             pulse_in;
    logic [WIDTH-1:0] period_out;
    logic             valid;
    logic             locked;
    logic             timeout;
    modport master (input clear, pulse_in, output period_out, valid, locked, timeout);
    modport slave  (output clear, pulse_in, input period_out, valid, locked, timeout);
endinterface

// File: rtl/period_meter_edge_sync_detect.sv
// edge_sync_detect: synchronises an async input and flags each rising edge for one cycle.
module edge_sync_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic async_in,
    output logic pulse_edge
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   history;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync    <= '0;
            history <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], async_in};
            history <= sync[SYNC_STAGES-1];
        end
    end
    assign pulse_edge = sync[SYNC_STAGES-1] & ~history;
endmodule

// File: rtl/period_meter.sv
// period_meter: counts clock cycles between rising edges of pulse_in and reports them in divider terms.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic          clock,
    input  logic          resetn,
    period_meter_if.master bus
);
    state_t           state, state_n;
    logic [WIDTH-1:0] count, count_n, period_n;
    logic             pulse_edge, valid_n, locked_n, timeout_n;

    edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock     (clock),
        .resetn    (resetn),
        .async_in  (bus.pulse_in),
        .pulse_edge(pulse_edge)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            count          <= '0;
            bus.period_out <= '0;
            bus.valid      <= 1'b0;
            bus.locked     <= 1'b0;
            bus.timeout    <= 1'b0;
        end else begin
            state          <= state_n;
            count          <= count_n;
            bus.period_out <= period_n;
            bus.valid      <= valid_n;
            bus.locked     <= locked_n;
            bus.timeout    <= timeout_n;
        end
    end

    // Edge beats timeout, so a period of exactly TIMEOUT is still reported.
    always_comb begin
        state_n   = state;
        count_n   = '0;
        period_n  = bus.period_out;
        valid_n   = 1'b0;
        locked_n  = bus.locked;
        timeout_n = 1'b0;
        if (state == IDLE) begin
            locked_n = bus.clear ? 1'b0 : bus.locked;
            state_n  = pulse_edge ? MEASURE : IDLE;
        end else if (bus.clear) begin
            state_n  = IDLE;
            locked_n = 1'b0;
        end else if (pulse_edge) begin
            period_n = count;
            valid_n  = 1'b1;
            locked_n = 1'b1;
        end else if (count == WIDTH'(TIMEOUT)) begin
            timeout_n = 1'b1;
            locked_n  = 1'b0;
            state_n   = IDLE;
        end else begin
            count_n = count + 1'b1;
        end
    end
endmodule
